// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_pkg
// Brief   : Shared op codes and checker state encoding for the 4-bit gate checker
// Revision: 1.0
// ============================================================================
package logic_pkg;

  localparam logic [1:0] OP_NAND = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_OR   = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_4b_ref.sv
`default_nettype none
// ============================================================================
// Module  : logic_4b_ref
// Brief   : Combinational golden model of the bitwise gate selected by OP
// Revision: 1.0
// ============================================================================
module logic_4b_ref
  import logic_pkg::*;
#(
  parameter int         WIDTH = 4,
  parameter logic [1:0] OP    = OP_NAND
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] exp_out
);

  always_comb begin
    exp_out = '0;
    case (OP)
      OP_NAND: exp_out = ~(x & y);
      OP_AND:  exp_out = x & y;
      OP_OR:   exp_out = x | y;
      OP_XOR:  exp_out = x ^ y;
      default: exp_out = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_4b_checker.sv
`default_nettype none
// ============================================================================
// Module  : logic_4b_checker
// Brief   : Response monitor that counts vectors/mismatches and captures the first failure
// Revision: 1.0
// ============================================================================
module logic_4b_checker
  import logic_pkg::*;
#(
  parameter int         WIDTH = 4,
  parameter logic [1:0] OP    = OP_NAND,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             last,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             finished,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y,
  output logic [WIDTH-1:0] first_err_out,
  output logic [WIDTH-1:0] first_err_exp
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t r_state, w_state_next;

  logic [WIDTH-1:0] w_exp;
  logic             w_sample, w_fail, w_new_run;
  logic [CNT_W-1:0] w_vec_inc, w_err_next;

  logic             r_pass, r_mismatch, r_first_valid;
  logic [CNT_W-1:0] r_vec, r_err, r_first_idx;
  logic [WIDTH-1:0] r_fx, r_fy, r_fout, r_fexp;

  logic_4b_ref #(.WIDTH(WIDTH), .OP(OP)) u_ref (
    .x      (x),
    .y      (y),
    .exp_out(w_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_RUN;
      ST_RUN:    if (in_valid && last) w_state_next = ST_REPORT;
      ST_REPORT: if (start) w_state_next = ST_RUN;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Case inequality makes any X/Z on the DUT result count as a failure.
  assign w_new_run  = start && (r_state != ST_RUN);
  assign w_sample   = (r_state == ST_RUN) && in_valid;
  assign w_fail     = w_sample && (dut_out !== w_exp);
  assign w_vec_inc  = (r_vec == c_cnt_max) ? r_vec : r_vec + c_cnt_one;
  assign w_err_next = !w_fail ? r_err :
                      (r_err == c_cnt_max) ? r_err : r_err + c_cnt_one;

  always_ff @(posedge clk) begin
    if (rst || w_new_run) begin
      r_pass        <= 1'b0;
      r_mismatch    <= 1'b0;
      r_first_valid <= 1'b0;
      r_vec         <= '0;
      r_err         <= '0;
      r_first_idx   <= '0;
      r_fx          <= '0;
      r_fy          <= '0;
      r_fout        <= '0;
      r_fexp        <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (w_sample) begin
        r_vec <= w_vec_inc;
        r_err <= w_err_next;
        if (w_fail && !r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_idx   <= r_vec;
          r_fx          <= x;
          r_fy          <= y;
          r_fout        <= dut_out;
          r_fexp        <= w_exp;
        end
        if (last) r_pass <= (w_err_next == '0);
      end
    end
  end

  assign busy          = (r_state == ST_RUN);
  assign finished      = (r_state == ST_REPORT);
  assign pass          = r_pass;
  assign mismatch      = r_mismatch;
  assign vec_count     = r_vec;
  assign err_count     = r_err;
  assign first_err_idx = r_first_idx;
  assign first_err_x   = r_fx;
  assign first_err_y   = r_fy;
  assign first_err_out = r_fout;
  assign first_err_exp = r_fexp;

endmodule
`default_nettype wire

// File: tb/tb_logic_4b_checker.sv
`default_nettype none
// Bench: three checker instances (NAND, AND, XOR) share one stimulus stream and are
// compared every cycle against a behavioural model, plus literal spot checks.
module tb_logic_4b_checker;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, last;
  logic [3:0] x, y, dut_out;

  logic       busy_a [3], fin_a [3], pass_a [3], mis_a [3];
  logic [7:0] vec_a [3], err_a [3], idx_a [3];
  logic [3:0] fx_a [3], fy_a [3], fo_a [3], fe_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam logic [1:0] c_op = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : 2'd3;
    logic_4b_checker #(.WIDTH(4), .OP(c_op), .CNT_W(8)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .last         (last),
      .x            (x),
      .y            (y),
      .dut_out      (dut_out),
      .busy         (busy_a[i]),
      .finished     (fin_a[i]),
      .pass         (pass_a[i]),
      .mismatch     (mis_a[i]),
      .vec_count    (vec_a[i]),
      .err_count    (err_a[i]),
      .first_err_idx(idx_a[i]),
      .first_err_x  (fx_a[i]),
      .first_err_y  (fy_a[i]),
      .first_err_out(fo_a[i]),
      .first_err_exp(fe_a[i])
    );
  end

  function automatic int op_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [3:0] ref_op(input int op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      0:       return ~(a & b);
      1:       return a & b;
      2:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Model: phase 0 = idle, 1 = running, 2 = reporting
  int         m_phase [3];
  int         m_vec [3], m_err [3], m_idx [3];
  bit         m_fv [3], m_mis [3], m_pass [3];
  logic [3:0] m_fx [3], m_fy [3], m_fo [3], m_fe [3];

  task automatic m_clear(input int k);
    m_vec[k] = 0; m_err[k] = 0; m_idx[k] = 0; m_fv[k] = 0; m_mis[k] = 0; m_pass[k] = 0;
    m_fx[k] = 0; m_fy[k] = 0; m_fo[k] = 0; m_fe[k] = 0;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_clear(k);
        m_phase[k] = 0;
      end else if (m_phase[k] != 1) begin
        m_mis[k] = 0;
        if (start) begin
          m_clear(k);
          m_phase[k] = 1;
        end
      end else begin
        m_mis[k] = 0;
        if (in_valid) begin
          logic [3:0] e;
          e = ref_op(op_of(k), x, y);
          if (dut_out !== e) begin
            if (!m_fv[k]) begin
              m_fv[k] = 1; m_idx[k] = m_vec[k];
              m_fx[k] = x; m_fy[k] = y; m_fo[k] = dut_out; m_fe[k] = e;
            end
            if (m_err[k] < 255) m_err[k]++;
            m_mis[k] = 1;
          end
          if (m_vec[k] < 255) m_vec[k]++;
          if (last) begin
            m_phase[k] = 2;
            m_pass[k] = (m_err[k] == 0);
          end
        end
      end
    end
  end

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h required %0h at %0t", k, name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk(k, "busy", 32'(busy_a[k]), 32'(m_phase[k] == 1));
      chk(k, "finished", 32'(fin_a[k]), 32'(m_phase[k] == 2));
      chk(k, "pass", 32'(pass_a[k]), 32'(m_pass[k]));
      chk(k, "mismatch", 32'(mis_a[k]), 32'(m_mis[k]));
      chk(k, "vec_count", 32'(vec_a[k]), 32'(m_vec[k]));
      chk(k, "err_count", 32'(err_a[k]), 32'(m_err[k]));
      chk(k, "first_err_idx", 32'(idx_a[k]), 32'(m_idx[k]));
      chk(k, "first_err_x", 32'(fx_a[k]), 32'(m_fx[k]));
      chk(k, "first_err_y", 32'(fy_a[k]), 32'(m_fy[k]));
      chk(k, "first_err_out", 32'(fo_a[k]), 32'(m_fo[k]));
      chk(k, "first_err_exp", 32'(fe_a[k]), 32'(m_fe[k]));
    end
  end

  task automatic drive(input logic s, input logic v, input logic l,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    start = s; in_valid = v; last = l; x = a; y = b; dut_out = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ra, rb, rd;
    rst = 1'b1; start = 0; in_valid = 0; last = 0; x = 0; y = 0; dut_out = 0;
    @(posedge clk); #1;
    do_reset();
    chk(0, "lit_reset_busy", 32'(busy_a[0]), 32'd0);

    // in_valid in IDLE is ignored
    drive(0, 1, 1, 4'b1000, 4'b1001, 4'b0000);
    chk(0, "lit_idle_vec", 32'(vec_a[0]), 32'd0);

    // Passing NAND run
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 0, 4'b1000, 4'b1001, 4'b0111);
    drive(0, 1, 1, 4'b1101, 4'b0110, 4'b1011);
    chk(0, "lit_run1_finished", 32'(fin_a[0]), 32'd1);
    chk(0, "lit_run1_pass", 32'(pass_a[0]), 32'd1);
    chk(0, "lit_run1_vec", 32'(vec_a[0]), 32'd2);
    chk(0, "lit_run1_err", 32'(err_a[0]), 32'd0);

    // in_valid in REPORT is ignored
    drive(0, 1, 0, 4'b0000, 4'b0000, 4'b0000);
    chk(0, "lit_report_vec", 32'(vec_a[0]), 32'd2);

    // AND-gate responses fed to the NAND checker
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    chk(0, "lit_restart_busy", 32'(busy_a[0]), 32'd1);
    chk(0, "lit_restart_vec", 32'(vec_a[0]), 32'd0);
    drive(0, 1, 0, 4'b1000, 4'b1001, 4'b1000);
    chk(0, "lit_run2_mis0", 32'(mis_a[0]), 32'd1);
    drive(0, 1, 1, 4'b1101, 4'b0110, 4'b0100);
    chk(0, "lit_run2_mis1", 32'(mis_a[0]), 32'd1);
    chk(0, "lit_run2_err", 32'(err_a[0]), 32'd2);
    chk(0, "lit_run2_pass", 32'(pass_a[0]), 32'd0);
    chk(0, "lit_run2_idx", 32'(idx_a[0]), 32'd0);
    chk(0, "lit_run2_fx", 32'(fx_a[0]), 32'b1000);
    chk(0, "lit_run2_fy", 32'(fy_a[0]), 32'b1001);
    chk(0, "lit_run2_fo", 32'(fo_a[0]), 32'b1000);
    chk(0, "lit_run2_fe", 32'(fe_a[0]), 32'b0111);
    chk(1, "lit_run2_and_pass", 32'(pass_a[1]), 32'd1);

    // start mid-RUN is not a restart
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 0, 4'b0011, 4'b0101, 4'b1110);
    drive(1, 1, 0, 4'b0011, 4'b0101, 4'b1110);
    chk(0, "lit_midrun_start_vec", 32'(vec_a[0]), 32'd2);
    chk(0, "lit_midrun_start_busy", 32'(busy_a[0]), 32'd1);

    // Reset mid-run, then a single passing vector
    drive(0, 1, 0, 4'b0011, 4'b0101, 4'b1110);
    do_reset();
    chk(0, "lit_midrun_rst_busy", 32'(busy_a[0]), 32'd0);
    chk(0, "lit_midrun_rst_vec", 32'(vec_a[0]), 32'd0);
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 1, 4'b1111, 4'b1010, 4'b0101);
    chk(0, "lit_post_rst_vec", 32'(vec_a[0]), 32'd1);
    chk(0, "lit_post_rst_pass", 32'(pass_a[0]), 32'd1);

    // Saturation: 300 vectors that fail the AND checker
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    for (int n = 0; n < 300; n++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      drive(0, 1, n == 299, ra, rb, ~(ra & rb));
    end
    chk(1, "lit_sat_vec", 32'(vec_a[1]), 32'd255);
    chk(1, "lit_sat_err", 32'(err_a[1]), 32'd255);
    chk(1, "lit_sat_idx", 32'(idx_a[1]), 32'd0);
    chk(1, "lit_sat_pass", 32'(pass_a[1]), 32'd0);
    chk(0, "lit_sat_nand_err", 32'(err_a[0]), 32'd0);

    // Unknown bits on the DUT result, XOR reference
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 1, 4'b0101, 4'b0100, 4'bxx01);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       rd = ~(ra & rb);
        1:       rd = ra & rb;
        2:       rd = ra ^ rb;
        default: rd = 4'($urandom);
      endcase
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 10, ra, rb, rd);
      rst = 1'b0;
    end

    drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
